// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared types and default widths for the ADC acquisition sequencer.
//   adc_state_e : sequencer FSM states
//   *_W_DEF     : default counter widths used as parameter defaults
// -----------------------------------------------------------------------------
package adc_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int SMP_W_DEF = 16;
  localparam int BST_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    WAIT_HI,
    WAIT_LO,
    TRIG,
    SLOT,
    GAP,
    DONE
  } adc_state_e;

endpackage

// File: rtl/adc_busy_sync.sv
// -----------------------------------------------------------------------------
// adc_busy_sync
// Multi-flop synchronizer bringing the asynchronous ADC busy line into aclk.
// Ports:
//   aclk    : system clock
//   areset  : synchronous active-high reset (clears all stages to 0)
//   busy    : raw asynchronous busy from the ADC
//   busy_s  : synchronized busy, SYNC_STAGES cycles of latency
// -----------------------------------------------------------------------------
module adc_busy_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic busy,
  output logic busy_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], busy};
    end
  end

  assign busy_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/adc_acq_sequencer.sv
// -----------------------------------------------------------------------------
// adc_acq_sequencer
// Counted, restartable ADC acquisition sequencer. Issues CNV pulses paced by
// a programmed divider, waits for each conversion on the ADC busy line, then
// raises one readout trigger per conversion, tagging the last sample of each
// burst. Bursts may be separated by idle gap cycles or repeat continuously.
//
// Optional build macro: ADC_SEQ_TIMEOUT_EN adds a busy watchdog and the
// sticky timeout_err output.
//
// Ports:
//   aclk, areset       : clock, synchronous active-high reset
//   start, stop        : single-cycle run start / graceful stop request
//   continuous         : repeat bursts until stopped
//   divider            : conversion period in aclk cycles (>=2)
//   samples_per_burst  : samples per burst (>=1)
//   num_bursts         : bursts per run (>=1, ignored when continuous)
//   gap_cycles         : idle cycles between bursts
//   busy               : asynchronous ADC busy
//   cnv                : ADC convert start
//   trigger, last      : readout strobe, final-sample-of-burst marker
//   running, done      : run active, one-cycle completion pulse
//   overrun, cfg_err   : sticky error flags
//   timeout_err        : sticky watchdog flag (ADC_SEQ_TIMEOUT_EN only)
//   fsm_state          : current FSM state, for debug/observation
//
// Handshake: trigger is a single-cycle strobe with no back-pressure; last is
// only meaningful while trigger is high. Config inputs are sampled once, on
// the cycle an accepted start is seen in IDLE.
// -----------------------------------------------------------------------------
module adc_acq_sequencer
  import adc_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int SMP_W        = SMP_W_DEF,
  parameter int BST_W        = BST_W_DEF,
  parameter int CNV_CYCLES   = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [CNT_W-1:0] divider,
  input  logic [SMP_W-1:0] samples_per_burst,
  input  logic [BST_W-1:0] num_bursts,
  input  logic [CNT_W-1:0] gap_cycles,
  input  logic             busy,
  output logic             cnv,
  output logic             trigger,
  output logic             last,
  output logic             running,
  output logic             done,
  output logic             overrun,
  output logic             cfg_err,
`ifdef ADC_SEQ_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output adc_state_e       fsm_state
);

  localparam int CNV_CW = (CNV_CYCLES > 1) ? $clog2(CNV_CYCLES) : 1;

  adc_state_e       state_q, state_d;
  logic             busy_s;

  logic [CNT_W-1:0] div_q, gap_q;
  logic [SMP_W-1:0] spb_q;
  logic [BST_W-1:0] nb_q;
  logic             cont_q;

  logic [CNT_W-1:0] period_cnt, gap_cnt, load_div;
  logic [SMP_W-1:0] sample_cnt;
  logic [BST_W-1:0] burst_cnt;
  logic [CNV_CW-1:0] cnv_cnt;
  logic             stop_pending;
  logic             prev_zero;
  logic             overrun_q, cfg_err_q;

  logic cfg_ok, start_ok, start_bad, stop_now, end_of_burst, more_bursts;

  adc_busy_sync #(.SYNC_STAGES(SYNC_STAGES)) u_busy_sync (
    .aclk   (aclk),
    .areset (areset),
    .busy   (busy),
    .busy_s (busy_s)
  );

  assign cfg_ok       = (divider >= CNT_W'(2)) && (samples_per_burst != '0) &&
                        ((num_bursts != '0) || continuous);
  assign start_ok     = (state_q == IDLE) && start && cfg_ok;
  assign start_bad    = (state_q == IDLE) && start && !cfg_ok;
  // A stop seen in the same cycle as TRIG/SLOT/GAP acts immediately.
  assign stop_now     = stop || stop_pending;
  assign end_of_burst = (sample_cnt == spb_q - SMP_W'(1));
  assign more_bursts  = cont_q || (burst_cnt < nb_q - BST_W'(1));
  // On the first CNV cycle out of IDLE the divider has not been latched yet.
  assign load_div     = (state_q == IDLE) ? divider : div_q;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(BUSY_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            timeout_q;
  assign wd_hit      = ((state_q == WAIT_HI) || (state_q == WAIT_LO)) &&
                       (wd_cnt == WD_W'(BUSY_TIMEOUT - 1));
  assign timeout_err = timeout_q;
`endif

  // Next-state and strobe outputs.
  always_comb begin
    state_d = state_q;
    cnv     = 1'b0;
    trigger = 1'b0;
    last    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = CNV;
      CNV: begin
        cnv = 1'b1;
        if (cnv_cnt == CNV_CW'(CNV_CYCLES - 1)) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (busy_s) state_d = WAIT_LO;
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (wd_hit) state_d = DONE;
`endif
      end
      WAIT_LO: begin
        if (!busy_s) state_d = TRIG;
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          trigger = 1'b1;
          last    = 1'b1;
          state_d = DONE;
        end
`endif
      end
      TRIG: begin
        trigger = 1'b1;
        last    = end_of_burst || stop_now;
        // When the period has already elapsed, skip SLOT so the next cnv
        // follows on the very next cycle.
        if (stop_now)                          state_d = DONE;
        else if (!end_of_burst)                state_d = (period_cnt == '0) ? CNV : SLOT;
        else if (more_bursts && gap_q != '0)   state_d = GAP;
        else if (more_bursts)                  state_d = (period_cnt == '0) ? CNV : SLOT;
        else                                   state_d = DONE;
      end
      SLOT: begin
        if (stop_now)                state_d = DONE;
        else if (period_cnt == '0)   state_d = CNV;
      end
      GAP: begin
        if (stop_now)                state_d = DONE;
        else if (gap_cnt == '0)      state_d = SLOT;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      gap_q        <= '0;
      spb_q        <= '0;
      nb_q         <= '0;
      cont_q       <= 1'b0;
      period_cnt   <= '0;
      gap_cnt      <= '0;
      sample_cnt   <= '0;
      burst_cnt    <= '0;
      cnv_cnt      <= '0;
      stop_pending <= 1'b0;
      prev_zero    <= 1'b0;
      overrun_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        div_q      <= divider;
        gap_q      <= gap_cycles;
        spb_q      <= samples_per_burst;
        nb_q       <= num_bursts;
        cont_q     <= continuous;
        sample_cnt <= '0;
        burst_cnt  <= '0;
        overrun_q  <= 1'b0;
        cfg_err_q  <= 1'b0;
      end else if (start_bad) begin
        cfg_err_q  <= 1'b1;
      end

      // Period counter: reloaded on every CNV entry, free-running down to 0.
      if (state_d == CNV && state_q != CNV) begin
        period_cnt <= load_div - CNT_W'(1);
      end else if (state_q != IDLE && period_cnt != '0) begin
        period_cnt <= period_cnt - CNT_W'(1);
      end
      // Zero in the cycle before TRIG means the slot start has already passed.
      prev_zero <= (state_q != IDLE) && (period_cnt == '0);

      if (state_q == CNV) cnv_cnt <= cnv_cnt + CNV_CW'(1);
      else                cnv_cnt <= '0;

      if (state_q == TRIG && state_d == GAP) begin
        gap_cnt <= gap_q - CNT_W'(1);
      end else if (state_q == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end

      if (state_q == TRIG && !stop_now) begin
        if (!end_of_burst) begin
          sample_cnt <= sample_cnt + SMP_W'(1);
        end else if (more_bursts) begin
          sample_cnt <= '0;
          if (burst_cnt != '1) burst_cnt <= burst_cnt + BST_W'(1);
        end
      end

      if (state_q == TRIG && prev_zero) overrun_q <= 1'b1;

      if (state_q == IDLE || state_q == DONE) stop_pending <= 1'b0;
      else if (stop)                          stop_pending <= 1'b1;
    end
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == WAIT_HI || state_q == WAIT_LO) wd_cnt <= wd_cnt + WD_W'(1);
      else                                          wd_cnt <= '0;
      if (start_ok)                                 timeout_q <= 1'b0;
      else if (wd_hit && state_d == DONE)           timeout_q <= 1'b1;
    end
  end
`endif

  assign running   = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign cfg_err   = cfg_err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_acq_sequencer
// Bench for adc_acq_sequencer: behavioural ADC busy model, negedge event
// monitor, and per-scenario tasks comparing observed cnv/trigger/last/done
// timing against expectations derived from the run configuration.
// -----------------------------------------------------------------------------
module tb_adc_acq_sequencer;

  localparam int CNT_W        = 32;
  localparam int SMP_W        = 16;
  localparam int BST_W        = 16;
  localparam int CNV_CYCLES   = 2;
  localparam int SYNC_STAGES  = 2;
  localparam int BUSY_TIMEOUT = 64;

  logic             aclk, areset, start, stop, continuous, busy;
  logic [CNT_W-1:0] divider, gap_cycles;
  logic [SMP_W-1:0] samples_per_burst;
  logic [BST_W-1:0] num_bursts;
  logic             cnv, trigger, last, running, done, overrun, cfg_err;
`ifdef ADC_SEQ_TIMEOUT_EN
  logic             timeout_err;
`endif
  adc_pkg::adc_state_e fsm_state;

  int checks   = 0;
  int failures = 0;

  adc_acq_sequencer #(
    .CNT_W(CNT_W), .SMP_W(SMP_W), .BST_W(BST_W), .CNV_CYCLES(CNV_CYCLES),
    .SYNC_STAGES(SYNC_STAGES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop),
    .continuous(continuous), .divider(divider),
    .samples_per_burst(samples_per_burst), .num_bursts(num_bursts),
    .gap_cycles(gap_cycles), .busy(busy), .cnv(cnv), .trigger(trigger),
    .last(last), .running(running), .done(done), .overrun(overrun),
    .cfg_err(cfg_err),
`ifdef ADC_SEQ_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- ADC model + monitor ----------------
  int   busy_len  = 3;   // 0 = busy stuck low
  int   busy_left = 0;
  logic cnv_prev  = 1'b0;

  int         cnv_t[$];
  int         trig_t[$];
  logic [0:0] trig_last[$];
  int         cnv_hi = 0;
  int         done_n = 0;
  int         done_t = 0;

  always @(negedge aclk) begin
    if (cnv && !cnv_prev) begin
      cnv_t.push_back(cyc);
      if (busy_len > 0) busy_left = busy_len;
    end
    busy = (busy_left != 0);
    if (busy_left != 0) busy_left--;
    if (cnv) cnv_hi++;
    if (trigger) begin
      trig_t.push_back(cyc);
      trig_last.push_back(last);
    end
    if (done) begin
      done_n++;
      done_t = cyc;
    end
    cnv_prev = cnv;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    cnv_t.delete();
    trig_t.delete();
    trig_last.delete();
    cnv_hi = 0;
    done_n = 0;
  endtask

  task automatic set_cfg(input int d, input int s, input int b, input int g, input logic c);
    divider           = CNT_W'(d);
    samples_per_burst = SMP_W'(s);
    num_bursts        = BST_W'(b);
    gap_cycles        = CNT_W'(g);
    continuous        = c;
  endtask

  task automatic pulse_start(input logic with_stop);
    @(posedge aclk); #1 start = 1'b1; stop = with_stop;
    @(posedge aclk); #1 start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      @(posedge aclk); #2;
      n++;
    end
    checks++;
    if (done_n == 0) begin
      failures++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  // Full counted run, checked against what the configuration implies.
  task automatic check_run(input int d, input int s, input int b, input int g,
                           input int blen, input logic with_stop, input string name);
    logic [0:0] exp_q[$];
    int n;
    n = s * b;
    busy_len = blen;
    clear_mon();
    set_cfg(d, s, b, g, 1'b0);
    pulse_start(with_stop);
    // Inputs scrambled mid-run must not alter the latched run.
    set_cfg($urandom_range(2, 4), $urandom_range(5, 9), $urandom_range(4, 7),
            $urandom_range(1, 3), 1'b1);
    @(negedge aclk);
    checks++;
    if (cfg_err !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL %s_started: cfg_err=%b running=%b want 0/1", name, cfg_err, running);
    end
    wait_done(n * (d + 20) + b * (g + 20) + 100, name);
    @(negedge aclk);

    for (int i = 0; i < n; i++) exp_q.push_back(((i % s) == s - 1) ? 1'b1 : 1'b0);

    checks++;
    if (trig_t.size() != n) begin
      failures++;
      $display("FAIL %s_trig_count: got %0d want %0d", name, trig_t.size(), n);
    end
    checks++;
    if (cnv_t.size() != n) begin
      failures++;
      $display("FAIL %s_cnv_count: got %0d want %0d", name, cnv_t.size(), n);
    end
    checks++;
    if (cnv_hi != n * CNV_CYCLES) begin
      failures++;
      $display("FAIL %s_cnv_width: got %0d high cycles want %0d", name, cnv_hi, n * CNV_CYCLES);
    end
    for (int i = 0; i < n && i < trig_last.size(); i++) begin
      checks++;
      if (trig_last[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_last[%0d]: got %b want %b", name, i, trig_last[i], exp_q[i]);
      end
    end
    if (cnv_t.size() == n && trig_t.size() == n) begin
      for (int k = 1; k < n; k++) begin
        checks++;
        if ((k % s) != 0 || g == 0) begin
          if (cnv_t[k] - cnv_t[k-1] != d) begin
            failures++;
            $display("FAIL %s_period[%0d]: got %0d want %0d", name, k, cnv_t[k] - cnv_t[k-1], d);
          end
        end else if (cnv_t[k] - trig_t[k-1] - 1 < g) begin
          failures++;
          $display("FAIL %s_gap[%0d]: got %0d idle cycles want >=%0d",
                   name, k, cnv_t[k] - trig_t[k-1] - 1, g);
        end
      end
      checks++;
      if (done_t != trig_t[n-1] + 1) begin
        failures++;
        $display("FAIL %s_done_time: got cycle %0d want %0d", name, done_t, trig_t[n-1] + 1);
      end
    end
    checks++;
    if (done_n != 1 || running !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: done_n=%0d running=%b overrun=%b want 1/0/0",
               name, done_n, running, overrun);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({cnv, trigger, last, running, done, overrun, cfg_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {cnv, trigger, last, running, done, overrun, cfg_err});
    end
    #1 areset = 1'b0;
  endtask

  task automatic test_single_burst();
    check_run(10, 4, 1, 0, 3, 1'b0, "single");
  endtask

  task automatic test_multi_burst();
    check_run(10, 2, 3, 20, 3, 1'b0, "multi");
  endtask

  task automatic test_overrun();
    busy_len = 8;
    clear_mon();
    set_cfg(5, 3, 1, 0, 1'b0);
    pulse_start(1'b0);
    wait_done(300, "overrun");
    @(negedge aclk);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag: got %b want 1", overrun);
    end
    checks++;
    if (trig_t.size() != 3 || cnv_t.size() != 3) begin
      failures++;
      $display("FAIL overrun_counts: trig=%0d cnv=%0d want 3/3", trig_t.size(), cnv_t.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (cnv_t[k] != trig_t[k-1] + 1) begin
          failures++;
          $display("FAIL overrun_next_cnv[%0d]: got cycle %0d want %0d", k, cnv_t[k], trig_t[k-1] + 1);
        end
      end
    end
  endtask

  task automatic test_stop();
    int n = 0;
    busy_len = 6;
    clear_mon();
    set_cfg(20, 3, 0, 0, 1'b1);
    pulse_start(1'b0);
    while (cnv_t.size() < 2 && n < 200) begin
      @(posedge aclk); #2;
      n++;
    end
    checks++;
    if (cnv_t.size() < 2) begin
      failures++;
      $display("FAIL stop_second_cnv: got %0d cnv want 2", cnv_t.size());
    end
    repeat (3) @(posedge aclk);
    #1 stop = 1'b1;
    @(posedge aclk); #1 stop = 1'b0;
    wait_done(200, "stop");
    repeat (30) @(negedge aclk);
    checks++;
    if (trig_last.size() != 2) begin
      failures++;
      $display("FAIL stop_trig_count: got %0d want 2", trig_last.size());
    end else begin
      checks++;
      if (trig_last[0] !== 1'b0 || trig_last[1] !== 1'b1) begin
        failures++;
        $display("FAIL stop_last: got %b%b want 01", trig_last[0], trig_last[1]);
      end
    end
    checks++;
    if (cnv_t.size() != 2 || done_n != 1 || running !== 1'b0) begin
      failures++;
      $display("FAIL stop_end: cnv=%0d done_n=%0d running=%b want 2/1/0",
               cnv_t.size(), done_n, running);
    end
  endtask

  task automatic bad_start(input int d, input int s, input int b, input string name);
    set_cfg(d, s, b, 0, 1'b0);
    pulse_start(1'b0);
    @(negedge aclk);
    checks++;
    if (cfg_err !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL %s: cfg_err=%b running=%b want 1/0", name, cfg_err, running);
    end
  endtask

  task automatic test_cfg_err();
    bad_start(1, 2, 1, "cfg_div1");
    check_run(8, 2, 1, 0, 2, 1'b0, "cfg_recover1");
    bad_start(10, 0, 1, "cfg_spb0");
    check_run(9, 1, 2, 3, 2, 1'b0, "cfg_recover2");
    bad_start(10, 2, 0, "cfg_nb0");
  endtask

  task automatic test_reset_mid_run();
    busy_len = 0;
    clear_mon();
    set_cfg(10, 2, 1, 0, 1'b0);
    pulse_start(1'b0);
    repeat (6) @(posedge aclk);
    #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({cnv, trigger, running, done} !== 4'b0) begin
      failures++;
      $display("FAIL midrun_reset: cnv/trig/run/done=%b want 0000", {cnv, trigger, running, done});
    end
    repeat (10) @(negedge aclk);
    checks++;
    if (done_n != 0 || running !== 1'b0 || trig_t.size() != 0) begin
      failures++;
      $display("FAIL midrun_after: done_n=%0d running=%b trig=%0d want 0/0/0",
               done_n, running, trig_t.size());
    end
  endtask

`ifdef ADC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    busy_len = 0;
    clear_mon();
    set_cfg(10, 2, 1, 0, 1'b0);
    pulse_start(1'b0);
    wait_done(BUSY_TIMEOUT + 50, "timeout");
    @(negedge aclk);
    checks++;
    if (timeout_err !== 1'b1 || trig_t.size() != 0 || done_n != 1) begin
      failures++;
      $display("FAIL timeout_end: timeout_err=%b trig=%0d done_n=%0d want 1/0/1",
               timeout_err, trig_t.size(), done_n);
    end
  endtask
`endif

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      check_run($urandom_range(12, 20), $urandom_range(1, 4), $urandom_range(1, 3),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15),
                $urandom_range(2, 4), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    areset = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    busy   = 1'b0;
    set_cfg(10, 4, 1, 0, 1'b0);
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_overrun();
    test_stop();
    test_cfg_err();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ADC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
